ctrl_pipe_chain: RTL

// Parametrised control-word pipeline from decode to writeback: NREG registered stages carrying a CW_W-bit

---
 rtl/ctrl_pipe_pkg.sv | 22 ++
 rtl/ctrl_pipe_chain_mc_timer.sv | 85 ++++++++
 rtl/ctrl_pipe_chain.sv | 105 ++++++++++
 3 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the decode-to-writeback control-word pipeline.
package ctrl_pipe_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    typedef struct packed {
        logic valid;
        logic mc;
    } stage_flags_t;

    localparam stage_flags_t FLAGS_BUBBLE = '{valid: 1'b0, mc: 1'b0};

    // Counter must hold MC_LAT-2 and still have headroom for MC_LAT=1.
    function automatic int unsigned mc_cnt_w(input int unsigned lat);
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/ctrl_pipe_chain_mc_timer.sv
// Multi-cycle-op timer: holds the EX register until its word has spent MC_LAT cycles there.
module mc_timer
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_valid,
    input  logic ex_mc,
    input  logic ex_load,
    input  logic ex_flush,
    output logic hold,
    output logic done
);

    localparam int unsigned     CNT_W     = mc_cnt_w(MC_LAT);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MC_LAT - 2);
    localparam logic            MULTI     = (MC_LAT > 1);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mc_word;

    assign mc_word = ex_valid & ex_mc & ~ex_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs depend only on state and EX contents so the hold chain has no loop.
    always_comb begin
        hold = 1'b0;
        done = 1'b0;
        case (state_q)
            MC_IDLE: begin
                hold = MULTI & mc_word;
                done = ~MULTI & mc_word;
            end
            MC_BUSY: begin
                hold = (cnt_q != '0);
                done = (cnt_q == '0) & ~ex_flush;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ex_flush) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MC_IDLE: begin
                    if (MULTI && mc_word) begin
                        state_d = MC_BUSY;
                        cnt_d   = CNT_START;
                    end
                end
                MC_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = ex_load ? MC_IDLE : MC_DONE;
                    end
                end
                MC_DONE: begin
                    if (ex_load) begin
                        state_d = MC_IDLE;
                    end
                end
                default: state_d = MC_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline ID->WB with per-stage stall/flush, bubble collapse and multi-cycle EX hold.
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned NREG   = 3,
    parameter int unsigned CW_W   = 24,
    parameter int unsigned EX_IDX = 0,
    parameter int unsigned MC_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW_W-1:0]      cw_d,
    input  logic                 valid_d,
    input  logic                 mc_d,
    input  logic [NREG-1:0]      stall_i,
    input  logic [NREG-1:0]      flush_i,
    output logic [NREG*CW_W-1:0] cw_q,
    output logic [NREG-1:0]      valid_q,
    output logic [NREG-1:0]      stall_o,
    output logic                 mc_busy,
    output logic                 mc_done
);

    logic [CW_W-1:0] cw_stage_q [NREG];
    stage_flags_t    flags_q    [NREG];
    logic [NREG-1:0] eff;
    logic            hold_below;
    logic            ex_hold;
    logic            ex_load;

    // Hold propagates upward only through occupied stages, so bubbles get squeezed out.
    always_comb begin
        eff        = '0;
        hold_below = 1'b0;
        for (int k = int'(NREG) - 1; k >= 0; k--) begin
            eff[k]     = stall_i[k] | ((k == int'(EX_IDX)) & ex_hold) | (flags_q[k].valid & hold_below);
            hold_below = eff[k];
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_stage
        logic [CW_W-1:0] prev_cw;
        stage_flags_t    prev_flags;
        logic            prev_held;
        logic [CW_W-1:0] cw_stage_d;
        stage_flags_t    flags_d;

        if (k == 0) begin : g_head
            assign prev_cw    = cw_d;
            assign prev_flags = '{valid: valid_d, mc: mc_d};
            assign prev_held  = 1'b0;
        end else begin : g_body
            assign prev_cw    = cw_stage_q[k-1];
            assign prev_flags = flags_q[k-1];
            assign prev_held  = eff[k-1];
        end

        always_comb begin
            cw_stage_d = prev_cw;
            flags_d    = prev_flags;
            if (flush_i[k]) begin
                cw_stage_d = '0;
                flags_d    = FLAGS_BUBBLE;
            end else if (eff[k]) begin
                cw_stage_d = cw_stage_q[k];
                flags_d    = flags_q[k];
            end else if (prev_held) begin
                cw_stage_d = '0;
                flags_d    = FLAGS_BUBBLE;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cw_stage_q[k] <= '0;
                flags_q[k]    <= FLAGS_BUBBLE;
            end else begin
                cw_stage_q[k] <= cw_stage_d;
                flags_q[k]    <= flags_d;
            end
        end

        assign cw_q[k*CW_W +: CW_W] = cw_stage_q[k];
        assign valid_q[k]           = flags_q[k].valid;
    end

    assign ex_load = ~eff[EX_IDX];

    mc_timer #(
        .MC_LAT (MC_LAT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (flags_q[EX_IDX].valid),
        .ex_mc    (flags_q[EX_IDX].mc),
        .ex_load  (ex_load),
        .ex_flush (flush_i[EX_IDX]),
        .hold     (ex_hold),
        .done     (mc_done)
    );

    assign mc_busy = ex_hold;
    assign stall_o = eff;

endmodule
